// File: rtl/utm_step_controller.sv
// Step sequencer for the Turing-machine datapath: fetch symbol, look up rule, write, move head.
// Optional build macro UTM_TAPE_FAULT_EN turns a wrapping head move into a FAULT stop.
module utm_step_controller #(
    parameter int STATE_BITS = 3,
    parameter int SYM_BITS   = 2,
    parameter int ADDR_BITS  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           step_mode,
    input  logic                           step,
    output logic [ADDR_BITS-1:0]           tape_addr,
    output logic                           tape_we,
    output logic [SYM_BITS-1:0]            tape_wdata,
    input  logic [SYM_BITS-1:0]            tape_rdata,
    output logic [STATE_BITS+SYM_BITS-1:0] rule_addr,
    input  logic [STATE_BITS+SYM_BITS:0]   rule_data,
    output logic                           busy,
    output logic                           halted,
    output logic                           fault,
    output logic [ADDR_BITS-1:0]           head,
    output logic [STATE_BITS-1:0]          cur_state,
    output logic [7:0]                     step_count,
    output logic [3:0]                     dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOOKUP = 4'd3,
        S_WRITE  = 4'd4,
        S_MOVE   = 4'd5,
        S_PAUSED = 4'd6,
        S_HALTED = 4'd7
`ifdef UTM_TAPE_FAULT_EN
        , S_FAULT = 4'd8
`endif
    } state_t;

    localparam logic [STATE_BITS-1:0] HALT = '1;
    localparam logic [ADDR_BITS-1:0]  ONE  = 1;

    state_t                          r_state;
    state_t                          w_next;
    logic [ADDR_BITS-1:0]            r_head;
    logic [STATE_BITS-1:0]           r_cur_state;
    logic [7:0]                      r_step_count;
    logic [SYM_BITS-1:0]             r_sym;
    logic [STATE_BITS+SYM_BITS:0]    r_rule;

    logic [STATE_BITS-1:0]           w_rule_next_state;
    logic [SYM_BITS-1:0]             w_rule_sym;
    logic                            w_rule_dir;
    logic [ADDR_BITS-1:0]            w_head_next;
    logic                            w_fault_stop;
    logic                            w_in_fault;
    logic                            w_restart_ok;

    assign w_rule_next_state = r_rule[STATE_BITS+SYM_BITS:SYM_BITS+1];
    assign w_rule_sym        = r_rule[SYM_BITS:1];
    assign w_rule_dir        = r_rule[0];
    assign w_head_next       = w_rule_dir ? (r_head + ONE) : (r_head - ONE);

`ifdef UTM_TAPE_FAULT_EN
    assign w_fault_stop = w_rule_dir ? (r_head == '1) : (r_head == '0);
    assign w_in_fault   = (r_state == S_FAULT);
`else
    assign w_fault_stop = 1'b0;
    assign w_in_fault   = 1'b0;
`endif

    assign w_restart_ok = (r_state == S_IDLE) || (r_state == S_HALTED) || w_in_fault;

    // start, step and abort are level commands sampled on each rising edge;
    // abort wins over start, start over step, and each is ignored where it has no meaning.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: if (start) w_next = S_FETCH;
                S_FETCH:          w_next = S_DECODE;
                S_DECODE:         w_next = S_LOOKUP;
                S_LOOKUP:         w_next = S_WRITE;
                S_WRITE:          w_next = S_MOVE;
                S_MOVE: begin
`ifdef UTM_TAPE_FAULT_EN
                    if (w_fault_stop)
                        w_next = S_FAULT;
                    else
`endif
                    if (w_rule_next_state == HALT)
                        w_next = S_HALTED;
                    else
                        w_next = step_mode ? S_PAUSED : S_FETCH;
                end
                S_PAUSED:         if (step) w_next = S_FETCH;
`ifdef UTM_TAPE_FAULT_EN
                S_FAULT:          if (start) w_next = S_FETCH;
`endif
                default:          w_next = S_IDLE;
            endcase
        end
    end

    // abort freezes the datapath so head/state/count stay visible after the stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_head       <= '0;
            r_cur_state  <= '0;
            r_step_count <= '0;
            r_sym        <= '0;
            r_rule       <= '0;
        end else begin
            r_state <= w_next;
            if (!abort) begin
                if (start && w_restart_ok) begin
                    r_head       <= '0;
                    r_cur_state  <= '0;
                    r_step_count <= '0;
                end
                case (r_state)
                    S_DECODE: r_sym  <= tape_rdata;
                    S_LOOKUP: r_rule <= rule_data;
                    S_MOVE: begin
                        r_cur_state <= w_rule_next_state;
                        if (r_step_count != 8'hFF)
                            r_step_count <= r_step_count + 8'd1;
                        if (!w_fault_stop)
                            r_head <= w_head_next;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tape_addr  = r_head;
    assign tape_we    = (r_state == S_WRITE) && !abort;
    assign tape_wdata = w_rule_sym;
    assign rule_addr  = {r_cur_state, r_sym};
    assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_LOOKUP) ||
                        (r_state == S_WRITE) || (r_state == S_MOVE) || (r_state == S_PAUSED);
    assign halted     = (r_state == S_HALTED);
    assign fault      = w_in_fault;
    assign head       = r_head;
    assign cur_state  = r_cur_state;
    assign step_count = r_step_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_utm_step_controller.sv
// Bench for utm_step_controller: tape RAM and rule table models plus an abstract Turing-machine reference.
`timescale 1ns/1ps
module tb_utm_step_controller;
  localparam int SB = 3, YB = 2, AB = 4;
  localparam logic [3:0] DBG_IDLE = 4'd0, DBG_WRITE = 4'd4, DBG_PAUSED = 4'd6, DBG_HALTED = 4'd7;
`ifdef UTM_TAPE_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic [AB-1:0] tape_addr;
  logic tape_we;
  logic [YB-1:0] tape_wdata, tape_rdata;
  logic [SB+YB-1:0] rule_addr;
  logic [SB+YB:0] rule_data;
  logic busy, halted, fault;
  logic [AB-1:0] head;
  logic [SB-1:0] cur_state;
  logic [7:0] step_count;
  logic [3:0] dbg_state;

  logic [YB-1:0] mem [16];
  logic [YB-1:0] pre_tape [16];
  logic pre_load = 1'b0;
  logic [SB+YB:0] rule_tbl [32];
  logic [5:0] wr_q[$];
  logic [5:0] exp_q[$];
  int n_checks = 0, n_pass = 0;

  logic [YB-1:0] m_tape [16];
  logic [AB-1:0] m_head;
  logic [SB-1:0] m_state;
  int m_count, m_steps;
  bit m_halted, m_fault;

  utm_step_controller #(.STATE_BITS(SB), .SYM_BITS(YB), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .step_mode(step_mode), .step(step),
    .tape_addr(tape_addr), .tape_we(tape_we), .tape_wdata(tape_wdata), .tape_rdata(tape_rdata),
    .rule_addr(rule_addr), .rule_data(rule_data), .busy(busy), .halted(halted), .fault(fault),
    .head(head), .cur_state(cur_state), .step_count(step_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= pre_tape[i];
    end else if (tape_we) begin
      mem[tape_addr] <= tape_wdata;
      wr_q.push_back({tape_addr, tape_wdata});
    end
    tape_rdata <= mem[tape_addr];
  end

  assign rule_data = rule_tbl[rule_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // Reference: run the machine step by step on an array tape until HALT, fault or max_steps.
  function automatic void model_run(int max_steps);
    logic [YB-1:0] sym;
    logic [SB+YB:0] r;
    logic [SB-1:0] ns;
    logic [YB-1:0] ws;
    bit wrap;
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_tape[i] = pre_tape[i];
    m_head = '0; m_state = '0; m_count = 0; m_steps = 0; m_halted = 0; m_fault = 0;
    while (m_steps < max_steps && !m_halted && !m_fault) begin
      sym = m_tape[m_head];
      r = rule_tbl[{m_state, sym}];
      ns = r[5:3];
      ws = r[2:1];
      m_tape[m_head] = ws;
      exp_q.push_back({m_head, ws});
      wrap = r[0] ? (m_head == 4'd15) : (m_head == 4'd0);
      m_state = ns;
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_steps++;
      if (FAULT_EN && wrap) m_fault = 1;
      else begin
        m_head = r[0] ? m_head + 4'd1 : m_head - 4'd1;
        if (ns == 3'd7) m_halted = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tape(input bit rnd);
    for (int i = 0; i < 16; i++) pre_tape[i] = rnd ? 2'($urandom_range(0, 3)) : 2'd0;
    pre_load = 1'b1;
    tick();
    pre_load = 1'b0;
  endtask

  task automatic set_counting_rules();
    for (int s = 0; s < 8; s++)
      for (int y = 0; y < 4; y++)
        rule_tbl[s*4 + y] = {(s == 6) ? 3'd7 : 3'(s + 1), 2'd1, 1'b1};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (halted !== 1'b0 || fault !== 1'b0) $display("FAIL reset_flags: halted %0b fault %0b want 0 0", halted, fault); else n_pass++;
    n_checks++; if (tape_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", tape_we); else n_pass++;
    n_checks++; if (head !== 4'd0 || cur_state !== 3'd0 || step_count !== 8'd0)
      $display("FAIL reset_regs: head %0d state %0d count %0d want 0 0 0", head, cur_state, step_count); else n_pass++;
    n_checks++; if (dbg_state !== DBG_IDLE) $display("FAIL reset_fsm: got %0d want %0d", dbg_state, DBG_IDLE); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_free_run(input string name);
    int cyc;
    bit wr_ok;
    set_counting_rules();
    load_tape(1'b0);
    wr_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 100) begin tick(); cyc++; end
    n_checks++; if (cyc !== 35) $display("FAIL %s_latency: got %0d cycles want 35", name, cyc); else n_pass++;
    n_checks++; if (halted !== 1'b1 || busy !== 1'b0) $display("FAIL %s_halted: halted %0b busy %0b want 1 0", name, halted, busy); else n_pass++;
    n_checks++; if (step_count !== 8'd7 || head !== 4'd7 || cur_state !== 3'd7)
      $display("FAIL %s_regs: count %0d head %0d state %0d want 7 7 7", name, step_count, head, cur_state); else n_pass++;
    wr_ok = (wr_q.size() == 7);
    for (int i = 0; i < wr_q.size() && i < 7; i++) if (wr_q[i] !== {4'(i), 2'd1}) wr_ok = 0;
    n_checks++; if (!wr_ok) $display("FAIL %s_writes: got %0d writes want 7 writes of 1 at 0..6", name, wr_q.size()); else n_pass++;
    repeat (3) tick();
    n_checks++; if (dbg_state !== DBG_HALTED || step_count !== 8'd7)
      $display("FAIL %s_hold: fsm %0d count %0d want %0d 7", name, dbg_state, step_count, DBG_HALTED); else n_pass++;
  endtask

  task automatic test_step_mode();
    bit cnt_ok;
    abort = 1'b1; tick(); abort = 1'b0;
    set_counting_rules();
    load_tape(1'b0);
    step_mode = 1'b1;
    wr_q.delete();
    step = 1'b1; tick(); step = 1'b0; tick();
    n_checks++; if (dbg_state !== DBG_IDLE || busy !== 1'b0 || wr_q.size() != 0)
      $display("FAIL step_in_idle: fsm %0d busy %0b writes %0d want %0d 0 0", dbg_state, busy, wr_q.size(), DBG_IDLE); else n_pass++;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    n_checks++; if (dbg_state !== DBG_PAUSED || busy !== 1'b1)
      $display("FAIL step_paused: fsm %0d busy %0b want %0d 1", dbg_state, busy, DBG_PAUSED); else n_pass++;
    n_checks++; if (wr_q.size() != 1 || head !== 4'd1)
      $display("FAIL step_first: writes %0d head %0d want 1 1", wr_q.size(), head); else n_pass++;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    n_checks++; if (wr_q.size() != 1 || step_count !== 8'd1 || busy !== 1'b1)
      $display("FAIL step_start_ignored: writes %0d count %0d busy %0b want 1 1 1", wr_q.size(), step_count, busy); else n_pass++;
    cnt_ok = 1;
    for (int k = 2; k <= 7; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      repeat (5) tick();
      if (wr_q.size() != k) cnt_ok = 0;
      repeat ($urandom_range(0, 4)) tick();
      if (wr_q.size() != k) cnt_ok = 0;
    end
    n_checks++; if (!cnt_ok) $display("FAIL step_one_per_pulse: writes %0d want 7", wr_q.size()); else n_pass++;
    n_checks++; if (halted !== 1'b1 || step_count !== 8'd7)
      $display("FAIL step_end: halted %0b count %0d want 1 7", halted, step_count); else n_pass++;
    step_mode = 1'b0;
  endtask

  task automatic test_start_abort();
    int cyc;
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    n_checks++; if (dbg_state !== DBG_IDLE || busy !== 1'b0)
      $display("FAIL start_abort_idle: fsm %0d busy %0b want %0d 0", dbg_state, busy, DBG_IDLE); else n_pass++;
    set_counting_rules();
    load_tape(1'b0);
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    repeat (2) begin tick(); cyc++; end
    start = 1'b1; tick(); start = 1'b0; cyc++;
    while (!halted && cyc < 100) begin tick(); cyc++; end
    n_checks++; if (cyc !== 35 || step_count !== 8'd7 || head !== 4'd7)
      $display("FAIL start_while_busy: cycles %0d count %0d head %0d want 35 7 7", cyc, step_count, head); else n_pass++;
  endtask

  task automatic test_abort_write();
    set_counting_rules();
    load_tape(1'b0);
    wr_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    repeat (13) tick();
    n_checks++; if (dbg_state !== DBG_WRITE || tape_we !== 1'b1)
      $display("FAIL abort_pre_write: fsm %0d we %0b want %0d 1", dbg_state, tape_we, DBG_WRITE); else n_pass++;
    abort = 1'b1; #1;
    n_checks++; if (tape_we !== 1'b0) $display("FAIL abort_we: got %0b want 0", tape_we); else n_pass++;
    tick(); abort = 1'b0;
    n_checks++; if (dbg_state !== DBG_IDLE || busy !== 1'b0)
      $display("FAIL abort_idle: fsm %0d busy %0b want %0d 0", dbg_state, busy, DBG_IDLE); else n_pass++;
    n_checks++; if (wr_q.size() != 2 || head !== 4'd2 || step_count !== 8'd2 || cur_state !== 3'd2)
      $display("FAIL abort_retain: writes %0d head %0d count %0d state %0d want 2 2 2 2", wr_q.size(), head, step_count, cur_state); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    set_counting_rules();
    load_tape(1'b0);
    wr_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    repeat (13) tick();
    reset = 1'b1; #1;
    n_checks++; if (tape_we !== 1'b0) $display("FAIL rst_write_we: got %0b want 0", tape_we); else n_pass++;
    n_checks++; if (dbg_state !== DBG_IDLE || head !== 4'd0 || step_count !== 8'd0 || cur_state !== 3'd0)
      $display("FAIL rst_write_regs: fsm %0d head %0d count %0d state %0d want 0 0 0 0", dbg_state, head, step_count, cur_state); else n_pass++;
    tick();
    n_checks++; if (wr_q.size() != 2) $display("FAIL rst_write_dropped: writes %0d want 2", wr_q.size()); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    for (int y = 0; y < 4; y++) rule_tbl[y] = {3'd0, 2'd2, 1'b0};
    load_tape(1'b0);
    wr_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
`ifdef UTM_TAPE_FAULT_EN
    n_checks++; if (fault !== 1'b1 || busy !== 1'b0)
      $display("FAIL wrap_fault: fault %0b busy %0b want 1 0", fault, busy); else n_pass++;
    n_checks++; if (head !== 4'd0 || step_count !== 8'd1 || cur_state !== 3'd0)
      $display("FAIL wrap_fault_regs: head %0d count %0d state %0d want 0 1 0", head, step_count, cur_state); else n_pass++;
    repeat (10) tick();
    n_checks++; if (wr_q.size() != 1 || fault !== 1'b1)
      $display("FAIL wrap_fault_hold: writes %0d fault %0b want 1 1", wr_q.size(), fault); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++; if (fault !== 1'b0 || dbg_state !== DBG_IDLE)
      $display("FAIL wrap_fault_abort: fault %0b fsm %0d want 0 %0d", fault, dbg_state, DBG_IDLE); else n_pass++;
`else
    n_checks++; if (head !== 4'd15 || step_count !== 8'd1)
      $display("FAIL wrap_first: head %0d count %0d want 15 1", head, step_count); else n_pass++;
    repeat (5) tick();
    n_checks++; if (head !== 4'd14 || fault !== 1'b0)
      $display("FAIL wrap_second: head %0d fault %0b want 14 0", head, fault); else n_pass++;
    repeat (5 * 258) tick();
    n_checks++; if (step_count !== 8'd255 || head !== 4'((16 - (260 % 16)) % 16) || busy !== 1'b1)
      $display("FAIL wrap_saturate: count %0d head %0d busy %0b want 255 %0d 1", step_count, head, busy, (16 - (260 % 16)) % 16); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++; if (dbg_state !== DBG_IDLE || step_count !== 8'd255)
      $display("FAIL wrap_abort: fsm %0d count %0d want %0d 255", dbg_state, step_count, DBG_IDLE); else n_pass++;
`endif
  endtask

  task automatic test_random(input int trials);
    int cyc, tries;
    bit wr_ok;
    logic [SB-1:0] ns;
    for (int t = 0; t < trials; t++) begin
      load_tape(1'b1);
      tries = 0;
      do begin
        for (int a = 0; a < 32; a++) begin
          ns = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
          if (tries >= 50) ns = 3'd7;
          rule_tbl[a] = {ns, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
        end
        model_run(60);
        tries++;
      end while (!m_halted && !m_fault);
      wr_q.delete();
      start = 1'b1; tick(); start = 1'b0;
      cyc = 0;
      while (!(halted || fault) && cyc < 5 * 60 + 20) begin tick(); cyc++; end
      n_checks++; if (cyc !== 5 * m_steps)
        $display("FAIL rand%0d_latency: got %0d cycles want %0d", t, cyc, 5 * m_steps); else n_pass++;
      n_checks++; if (halted !== m_halted || fault !== m_fault || busy !== 1'b0)
        $display("FAIL rand%0d_end: halted %0b fault %0b busy %0b want %0b %0b 0", t, halted, fault, busy, m_halted, m_fault); else n_pass++;
      n_checks++; if (head !== m_head || cur_state !== m_state || step_count !== 8'(m_count))
        $display("FAIL rand%0d_regs: head %0d state %0d count %0d want %0d %0d %0d", t, head, cur_state, step_count, m_head, m_state, m_count); else n_pass++;
      wr_ok = (wr_q.size() == exp_q.size());
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i]) wr_ok = 0;
      n_checks++; if (!wr_ok) $display("FAIL rand%0d_writes: got %0d writes want %0d (or contents differ)", t, wr_q.size(), exp_q.size()); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run("free_run");
    test_free_run("restart");
    test_step_mode();
    test_start_abort();
    test_abort_write();
    test_reset_mid_write();
    test_wrap();
    test_random(8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/utm_step_controller.md
Name: utm_step_controller

Overview:
- Sequencing FSM for the Turing-machine datapath. Drives an external tape RAM and an external transition-rule table.
- Each machine step: read the symbol under the head, look up the rule, write the new symbol, move the head, update the machine state.
- Sits inside the user module, between the io_in/io_out pin mapping and the tape/rule storage.
- Supports free-run and single-step modes, and halt detection.

Parameters:
- STATE_BITS, 3, width of machine-state register; state value all-ones is HALT.
- SYM_BITS, 2, tape symbol width.
- ADDR_BITS, 4, tape address width; tape depth = 2**ADDR_BITS.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin run from head=0, state=0; honoured in IDLE or HALTED (or FAULT when macro on).
- abort  input  1  synchronous return to IDLE from any state.
- step_mode  input  1  1 = pause after every step.
- step  input  1  advance one step while PAUSED.
- tape_addr  output  ADDR_BITS  tape RAM address.
- tape_we  output  1  tape write enable.
- tape_wdata  output  SYM_BITS  tape write data.
- tape_rdata  input  SYM_BITS  tape read data; synchronous RAM, valid one cycle after tape_addr.
- rule_addr  output  STATE_BITS+SYM_BITS  {cur_state, sym}.
- rule_data  input  STATE_BITS+SYM_BITS+1  {next_state, write_sym, dir}; combinational, valid same cycle.
- busy  output  1  high in FETCH..MOVE and PAUSED.
- halted  output  1  high in HALTED.
- fault  output  1  see Optional Feature.
- head  output  ADDR_BITS  head position.
- cur_state  output  STATE_BITS  machine state.
- step_count  output  8  completed steps, saturating.

Behaviour:
- Reset (async): FSM=IDLE; head, cur_state, step_count, sym_reg, rule_reg = 0; tape_we=0; busy, halted, fault = 0.
- FSM states: IDLE, FETCH, DECODE, LOOKUP, WRITE, MOVE, PAUSED, HALTED, plus FAULT when the macro is defined.
- IDLE: start -> clear head/cur_state/step_count, go to FETCH.
- FETCH: tape_addr=head -> DECODE.
- DECODE: sym_reg <= tape_rdata -> LOOKUP.
- LOOKUP: rule_addr={cur_state,sym_reg}; rule_reg <= rule_data -> WRITE.
- WRITE: tape_we=1 for exactly this cycle, tape_addr=head, tape_wdata=rule_reg.write_sym -> MOVE.
- MOVE:
  - dir=1: head+1; dir=0: head-1; modulo 2**ADDR_BITS.
  - cur_state <= next_state; step_count+1, saturating at 255.
  - next_state==HALT -> HALTED; else step_mode ? PAUSED : FETCH.
- Step latency: 5 cycles in free-run.
- PAUSED: step -> FETCH; start ignored.
- HALTED: holds all registers; start -> restart exactly as from IDLE.
- abort: next state IDLE, taking effect on the next clock from any state. If asserted during WRITE, tape_we is forced 0 that cycle. head, cur_state and step_count are retained for inspection.
- Priority: abort > start > step. start while busy is ignored.
- tape_addr=head in all states other than those above; tape_we=0 outside WRITE.
- Wrap: head=2**ADDR_BITS-1 moving right -> 0; head=0 moving left -> 2**ADDR_BITS-1.
- Reset mid-step: immediate return to IDLE; any in-flight write is dropped.

Optional Feature:
- Macro: UTM_TAPE_FAULT_EN.
- Defined:
  - A MOVE that would wrap goes to FAULT instead.
  - head is unchanged; cur_state and step_count are updated; fault=1, busy=0.
  - FAULT is left only by start (restart) or abort (-> IDLE, fault cleared).
- Undefined: wrap-around as above; fault tied to 0; no FAULT state.

Test Plan:
- Reset mid-WRITE -> tape_we=0 immediately; FSM IDLE, head=0, step_count=0.
- Rule table: every {s, sym} -> {s+1, 1, right}, state 6 -> HALT (7); start -> 7 writes of symbol 1 at addresses 0..6; halted=1 after 35 cycles; step_count=7, head=7.
- step_mode=1, one step pulse per pause -> exactly one write per pulse; busy stays 1 in PAUSED; step ignored in IDLE.
- Rule {0, any} -> {0, 2, left} from head=0:
  - Macro off: head goes to 15, 14, ...; step_count saturates at 255 after 255 steps.
  - Macro on: fault=1 after the first MOVE, head=0, no further tape writes.
- abort asserted in the same cycle as WRITE -> no tape write; next FSM state IDLE.
- start and abort asserted together in IDLE -> stays IDLE; start alone while busy -> ignored, step_count unaffected.
